// File: rtl/ttt_game_ctrl.sv
// ============================================================================
// ttt_game_ctrl : tic-tac-toe sequencer - key press decode, board, win/draw
// Revision 1.0
// ============================================================================
`default_nettype none

module ttt_game_ctrl #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int TW          = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] key_data,
  output logic [17:0] board,
  output logic        is_main,
  output logic        is_turn_o,
  output logic        is_right,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [8:0]  win_mask,
  output logic [3:0]  move_count,
  output logic        illegal
);

  typedef enum logic [1:0] {S_MAIN, S_PLAY, S_CHECK, S_OVER} state_t;

  localparam logic [TW-1:0] TIMER_LAST = TW'(HOLD_CYCLES - 1);
  // Rows, columns, then both diagonals as 9-bit cell masks.
  localparam logic [71:0] LINE_MASKS = {9'h007, 9'h038, 9'h1C0, 9'h049,
                                        9'h092, 9'h124, 9'h111, 9'h054};

  state_t         state_q, state_d;
  logic [17:0]    board_q, board_d;
  logic           is_turn_o_q, is_turn_o_d;
  logic           is_right_q, is_right_d;
  logic [1:0]     winner_q, winner_d;
  logic [8:0]     win_mask_q, win_mask_d;
  logic [3:0]     move_count_q, move_count_d;
  logic           illegal_q, illegal_d;
  logic [11:0]    key_prev_q, key_prev_d;
  logic [TW-1:0]  timer_q, timer_d;

  logic           press, star_press, hash_press, cell_press, cell_occ;
  logic [1:0]     mover;
  logic [8:0]     is_mover, line_hits, line_m;

  always_comb begin
    press      = (key_prev_q == 12'd0) && (key_data != 12'd0) &&
                 ((key_data & (key_data - 12'd1)) == 12'd0);
    star_press = press && key_data[9];
    hash_press = press && key_data[11];
    cell_press = press && (key_data[8:0] != 9'd0);
    mover      = is_turn_o_q ? 2'd2 : 2'd1;
    cell_occ   = 1'b0;
    is_mover   = '0;
    line_hits  = '0;
    line_m     = '0;
    for (int i = 0; i < 9; i++) begin
      if (key_data[i] && (board_q[2*i +: 2] != 2'd0)) cell_occ = 1'b1;
      is_mover[i] = (board_q[2*i +: 2] == mover);
    end
    for (int l = 0; l < 8; l++) begin
      line_m = LINE_MASKS[9*l +: 9];
      if ((is_mover & line_m) == line_m) line_hits = line_hits | line_m;
    end
  end

  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    is_turn_o_d  = is_turn_o_q;
    is_right_d   = is_right_q ^ hash_press;
    winner_d     = winner_q;
    win_mask_d   = win_mask_q;
    move_count_d = move_count_q;
    illegal_d    = 1'b0;
    key_prev_d   = key_data;
    timer_d      = timer_q;
    case (state_q)
      S_MAIN, S_PLAY: begin
        if (star_press) begin
          board_d      = '0;
          move_count_d = '0;
          is_turn_o_d  = 1'b0;
          winner_d     = 2'd0;
          win_mask_d   = '0;
          state_d      = S_PLAY;
        end else if (state_q == S_PLAY && cell_press) begin
          if (cell_occ) begin
            illegal_d = 1'b1;
          end else begin
            for (int i = 0; i < 9; i++)
              if (key_data[i]) board_d[2*i +: 2] = mover;
            move_count_d = move_count_q + 4'd1;
            state_d      = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (line_hits != 9'd0) begin
          winner_d   = mover;
          win_mask_d = line_hits;
          timer_d    = '0;
          state_d    = S_OVER;
        end else if (move_count_q == 4'd9) begin
          winner_d   = 2'd0;
          win_mask_d = '0;
          timer_d    = '0;
          state_d    = S_OVER;
        end else begin
          is_turn_o_d = ~is_turn_o_q;
          state_d     = S_PLAY;
        end
      end
      S_OVER: begin
        timer_d = timer_q + 1'b1;
        // Board, winner and mask stay visible after the return to MAIN.
        if (star_press || timer_q == TIMER_LAST) state_d = S_MAIN;
      end
      default: state_d = S_MAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_MAIN;
      board_q      <= '0;
      is_turn_o_q  <= 1'b0;
      is_right_q   <= 1'b0;
      winner_q     <= 2'd0;
      win_mask_q   <= '0;
      move_count_q <= '0;
      illegal_q    <= 1'b0;
      key_prev_q   <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      is_turn_o_q  <= is_turn_o_d;
      is_right_q   <= is_right_d;
      winner_q     <= winner_d;
      win_mask_q   <= win_mask_d;
      move_count_q <= move_count_d;
      illegal_q    <= illegal_d;
      key_prev_q   <= key_prev_d;
      timer_q      <= timer_d;
    end
  end

  assign board      = board_q;
  assign is_main    = (state_q == S_MAIN);
  assign game_over  = (state_q == S_OVER);
  assign is_turn_o  = is_turn_o_q;
  assign is_right   = is_right_q;
  assign winner     = winner_q;
  assign win_mask   = win_mask_q;
  assign move_count = move_count_q;
  assign illegal    = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_ttt_game_ctrl.sv
// ============================================================================
// tb_ttt_game_ctrl : directed scoreboard bench for ttt_game_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ttt_game_ctrl;

  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] key_data = '0;
  logic [17:0] board;
  logic        is_main, is_turn_o, is_right, game_over, illegal;
  logic [1:0]  winner;
  logic [8:0]  win_mask;
  logic [3:0]  move_count;

  ttt_game_ctrl #(.HOLD_CYCLES(HOLD), .TW(4)) dut (
    .clk(clk), .rst(rst), .key_data(key_data), .board(board),
    .is_main(is_main), .is_turn_o(is_turn_o), .is_right(is_right),
    .game_over(game_over), .winner(winner), .win_mask(win_mask),
    .move_count(move_count), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  // Reference model of the game
  logic [17:0] m_board;
  logic        m_main, m_turn, m_right, m_over;
  logic [1:0]  m_winner;
  logic [8:0]  m_mask;
  logic [3:0]  m_count;

  function automatic logic [31:0] obs(int sel);
    case (sel)
      0: return 32'(board);
      1: return 32'(is_main);
      2: return 32'(is_turn_o);
      3: return 32'(is_right);
      4: return 32'(game_over);
      5: return 32'(winner);
      6: return 32'(win_mask);
      7: return 32'(move_count);
      8: return 32'(illegal);
      default: return '1;
    endcase
  endfunction

  function automatic logic [8:0] model_mask(logic [17:0] b, logic [1:0] v);
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    logic [8:0] m = '0;
    for (int l = 0; l < 8; l++) begin
      if (b[2*lines[l][0] +: 2] == v && b[2*lines[l][1] +: 2] == v &&
          b[2*lines[l][2] +: 2] == v) begin
        m[lines[l][0]] = 1'b1;
        m[lines[l][1]] = 1'b1;
        m[lines[l][2]] = 1'b1;
      end
    end
    return m;
  endfunction

  task automatic cmp(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
    end
  endtask

  task automatic push(string tag, int sel, logic [31:0] v);
    exp_t x;
    x.tag = tag;
    x.sel = sel;
    x.val = v;
    sb.push_back(x);
  endtask

  task automatic push_all(string tag);
    push({tag, "/board"},      0, 32'(m_board));
    push({tag, "/is_main"},    1, 32'(m_main));
    push({tag, "/is_turn_o"},  2, 32'(m_turn));
    push({tag, "/is_right"},   3, 32'(m_right));
    push({tag, "/game_over"},  4, 32'(m_over));
    push({tag, "/winner"},     5, 32'(m_winner));
    push({tag, "/win_mask"},   6, 32'(m_mask));
    push({tag, "/move_count"}, 7, 32'(m_count));
    push({tag, "/illegal"},    8, 32'd0);
  endtask

  task automatic flush();
    while (sb.size() > 0) begin
      exp_t x = sb.pop_front();
      cmp(x.tag, obs(x.sel), x.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(logic [11:0] code);
    key_data = code;
    tick();
    key_data = '0;
    tick();
  endtask

  task automatic model_reset();
    m_board = '0; m_main = 1'b1; m_turn = 1'b0; m_right = 1'b0;
    m_over = 1'b0; m_winner = 2'd0; m_mask = '0; m_count = '0;
  endtask

  task automatic model_star();
    if (m_over) begin
      m_over = 1'b0;
      m_main = 1'b1;
    end else begin
      m_board = '0; m_count = '0; m_turn = 1'b0; m_winner = 2'd0;
      m_mask = '0; m_main = 1'b0;
    end
  endtask

  task automatic model_place(int k);
    logic [1:0] v = m_turn ? 2'd2 : 2'd1;
    logic [8:0] mk;
    m_board[2*k +: 2] = v;
    m_count = m_count + 4'd1;
    mk = model_mask(m_board, v);
    if (mk != 9'd0) begin
      m_over = 1'b1; m_winner = v; m_mask = mk;
    end else if (m_count == 4'd9) begin
      m_over = 1'b1; m_winner = 2'd0; m_mask = '0;
    end else begin
      m_turn = ~m_turn;
    end
  endtask

  task automatic star(string tag);
    press(12'h200);
    model_star();
    push_all(tag);
    flush();
  endtask

  task automatic play(int k);
    press(12'(1 << k));
    model_place(k);
    push_all($sformatf("play%0d", k + 1));
    flush();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    model_reset();
    tick();
    tick();
    push_all("reset");
    flush();
    rst = 1'b1;
    tick();

    press(12'h800);
    m_right = 1'b1;
    push_all("hash_main");
    flush();

    press(12'h001);
    push_all("cell_in_main");
    flush();

    star("start");

    press(12'h800);
    m_right = 1'b0;
    push_all("hash_play");
    flush();

    // X wins on the top row
    play(0); play(3); play(1); play(4); play(2);
    cmp("win_board", 32'(board), 32'h00295);
    cmp("win_winner", 32'(winner), 32'd1);
    cmp("win_mask_row0", 32'(win_mask), 32'h007);
    cmp("win_count", 32'(move_count), 32'd5);

    n = 0;
    while (!is_main && n < 50) begin
      tick();
      n++;
    end
    cmp("hold_length", 32'(n), 32'(HOLD));
    m_over = 1'b0;
    m_main = 1'b1;
    push_all("after_timeout");
    flush();

    star("restart");
    play(4);
    key_data = 12'h010;
    tick();
    cmp("illegal_high", 32'(illegal), 32'd1);
    key_data = '0;
    tick();
    cmp("illegal_low", 32'(illegal), 32'd0);
    push_all("after_illegal");
    flush();
    cmp("illegal_turn", 32'(is_turn_o), 32'd1);
    cmp("illegal_count", 32'(move_count), 32'd1);

    star("restart_in_play");
    foreach (draw_seq[i]) play(draw_seq[i]);
    cmp("draw_over", 32'(game_over), 32'd1);
    cmp("draw_winner", 32'(winner), 32'd0);
    cmp("draw_mask", 32'(win_mask), 32'd0);
    cmp("draw_count", 32'(move_count), 32'd9);

    press(12'h800);
    m_right = ~m_right;
    push_all("hash_over");
    flush();

    star("star_over");
    star("start2");

    // A held key places exactly one stone
    key_data = 12'h010;
    repeat (20) tick();
    key_data = '0;
    tick();
    model_place(4);
    push_all("held_key");
    flush();

    press(12'h011);
    push_all("two_bit_code");
    flush();

    play(0);
    rst = 1'b0;
    tick();
    model_reset();
    push_all("mid_reset");
    flush();
    rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
